se_arbiter: RTL

Round-robin arbiter that shares the single MAC search engine among several frame processors. Each processor drives its own lookup handshake (se_req/se_source/se_mac/se_hash, answered by se_ack/se_nak/se_result). A processor keeps se_req high across its source lookup and its destination lookup, so the arbiter grants the engine for a whole session, not per lookup. A watchdog converts a hung lookup into a nak so that no processor stalls forever.

---
 rtl/se_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/se_arbiter.sv
// Round-robin arbiter sharing one MAC search engine among NREQ frame processors.
// A grant lasts for a whole session (request held high); a watchdog naks hung lookups.
module se_arbiter #(
  parameter int NREQ    = 4,
  parameter int IW      = $clog2(NREQ),
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    m_se_req,
  input  logic [NREQ-1:0]    m_se_source,
  input  logic [48*NREQ-1:0] m_se_mac,
  input  logic [10*NREQ-1:0] m_se_hash,
  output logic [NREQ-1:0]    m_se_ack,
  output logic [NREQ-1:0]    m_se_nak,
  output logic [15:0]        m_se_result,
  output logic               se_req,
  output logic               se_source,
  output logic [47:0]        se_mac,
  output logic [9:0]         se_hash,
  input  logic               se_ack,
  input  logic               se_nak,
  input  logic [15:0]        se_result,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic               timeout_err,
  input  logic               err_clr
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [15:0]   wd_cnt_q, wd_cnt_d;
  logic          timeout_err_q, timeout_err_d;

  logic [47:0]   mac_a  [NREQ];
  logic [9:0]    hash_a [NREQ];
  logic          pick_vld;
  logic [IW-1:0] pick;
  logic [IW:0]   cand;
  logic [IW-1:0] grant_nxt;
  logic          req_sel;
  logic          wd_fire;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign mac_a[i]  = m_se_mac[48*i +: 48];
    assign hash_a[i] = m_se_hash[10*i +: 10];
  end

  // First asserted requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!pick_vld && m_se_req[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[IW-1:0];
      end
    end
  end

  assign grant_nxt = (grant_q == IW'(NREQ-1)) ? '0 : grant_q + 1'b1;
  assign req_sel   = m_se_req[grant_q];
  assign wd_fire   = (state_q == S_BUSY) && req_sel && !se_ack && !se_nak &&
                     (wd_cnt_q == 16'(TIMEOUT-1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      ptr_q         <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    wd_cnt_d      = '0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: if (pick_vld) begin
        state_d = S_BUSY;
        grant_d = pick;
      end
      S_BUSY: if (!req_sel) begin
        state_d = S_IDLE;
        ptr_d   = grant_nxt;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_BUSY && req_sel && !se_ack && !se_nak && !wd_fire)
      wd_cnt_d = wd_cnt_q + 16'd1;
    // Expiry wins over a simultaneous clear.
    if (wd_fire)      timeout_err_d = 1'b1;
    else if (err_clr) timeout_err_d = 1'b0;
  end

  always_comb begin
    se_req    = 1'b0;
    se_source = 1'b0;
    se_mac    = '0;
    se_hash   = '0;
    m_se_ack  = '0;
    m_se_nak  = '0;
    if (state_q == S_BUSY) begin
      se_req             = req_sel;
      se_source          = m_se_source[grant_q];
      se_mac             = mac_a[grant_q];
      se_hash            = hash_a[grant_q];
      m_se_ack[grant_q]  = se_ack;
      m_se_nak[grant_q]  = se_nak | wd_fire;
    end
  end

  assign m_se_result = se_result;
  assign busy        = (state_q == S_BUSY);
  assign grant_id    = busy ? grant_q : '0;
  assign timeout_err = timeout_err_q;

endmodule
